// File: rtl/program_loader.sv
// Loads WORD_COUNT big-endian instruction words from a byte stream into instruction memory.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module program_loader #(
  parameter int unsigned WORD_COUNT = 44
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        startLoading,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [31:0] imemAddr,
  output logic [31:0] imemData,
  output logic        imemWrite,
  output logic        programLoaded,
  output logic        loadError
);

  localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSEMBLE = 3'd1,
    ST_WRITE    = 3'd2,
    ST_DONE     = 3'd3
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    ST_CHECK    = 3'd4,
    ST_ERROR    = 3'd5
`endif
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic             last_word;

  assign last_word = (word_idx == IDX_W'(WORD_COUNT - 1));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`else
  assign loadError = 1'b0;
`endif

  // Load sequencer; a dropped startLoading aborts any in-progress load back to IDLE.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= ST_IDLE;
      word_idx      <= '0;
      byte_cnt      <= '0;
      byteReady     <= 1'b0;
      imemAddr      <= '0;
      imemData      <= '0;
      imemWrite     <= 1'b0;
      programLoaded <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum          <= '0;
      loadError     <= 1'b0;
`endif
    end else begin
      imemWrite <= 1'b0;
      case (state)
        ST_IDLE: begin
          byteReady <= 1'b0;
          if (startLoading) begin
            state     <= ST_ASSEMBLE;
            byteReady <= 1'b1;
            word_idx  <= '0;
            byte_cnt  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end

        ST_ASSEMBLE: begin
          if (!startLoading) begin
            state     <= ST_IDLE;
            byteReady <= 1'b0;
            word_idx  <= '0;
            byte_cnt  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end else if (byteValid && byteReady) begin
            imemData <= {imemData[23:0], byteData};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= csum + byteData;
`endif
            if (byte_cnt == 2'd3) begin
              byte_cnt  <= '0;
              state     <= ST_WRITE;
              byteReady <= 1'b0;
              imemWrite <= 1'b1;
              imemAddr  <= 32'(word_idx) << 2;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        ST_WRITE: begin
          if (!startLoading) begin
            state     <= ST_IDLE;
            byteReady <= 1'b0;
            word_idx  <= '0;
            byte_cnt  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end else if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state         <= ST_CHECK;
            byteReady     <= 1'b1;
`else
            state         <= ST_DONE;
            programLoaded <= 1'b1;
`endif
          end else begin
            word_idx  <= word_idx + IDX_W'(1);
            state     <= ST_ASSEMBLE;
            byteReady <= 1'b1;
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (!startLoading) begin
            state     <= ST_IDLE;
            byteReady <= 1'b0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
          end else if (byteValid && byteReady) begin
            byteReady <= 1'b0;
            if (byteData == csum) begin
              state         <= ST_DONE;
              programLoaded <= 1'b1;
            end else begin
              state     <= ST_ERROR;
              loadError <= 1'b1;
            end
          end
        end

        ST_ERROR: begin
          byteReady     <= 1'b0;
          programLoaded <= 1'b0;
        end
`endif

        ST_DONE: begin
          byteReady <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          byteReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and randomized loads against a byte-stream model.
module tb_program_loader;

  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        startLoading;
  logic [7:0]  byteData;
  logic        byteValid;
  logic        byteReady;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        imemWrite;
  logic        programLoaded;
  logic        loadError;

  program_loader #(.WORD_COUNT(WC)) dut (
    .CLOCK_50      (clk),
    .RESET_N       (rst_n),
    .startLoading  (startLoading),
    .byteData      (byteData),
    .byteValid     (byteValid),
    .byteReady     (byteReady),
    .imemAddr      (imemAddr),
    .imemData      (imemData),
    .imemWrite     (imemWrite),
    .programLoaded (programLoaded),
    .loadError     (loadError)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] stim[$];
  logic       prev_wr = 1'b0;

  // Capture every write strobe and confirm it never lasts more than one cycle.
  always @(negedge clk) begin
    if (imemWrite === 1'b1) begin
      wr_t w;
      w.addr = imemAddr;
      w.data = imemData;
      got_q.push_back(w);
      n_checks++;
      if (prev_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL write_pulse_width: imemWrite high on consecutive cycles at addr %h", imemAddr);
      end
    end
    prev_wr = imemWrite;
  end

  // Reference: consecutive groups of four bytes, first byte most significant, at addresses 4*w.
  task automatic model_load(input int nwords);
    exp_q.delete();
    for (int w = 0; w < nwords; w++) begin
      wr_t e;
      e.addr = 32'(4 * w);
      e.data = (32'(stim[4*w]) << 24) | (32'(stim[4*w+1]) << 16) |
               (32'(stim[4*w+2]) << 8) | 32'(stim[4*w+3]);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [7:0] byte_sum(input int n);
    int s = 0;
    for (int k = 0; k < n; k++) s += int'(stim[k]);
    return 8'(s % 256);
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    startLoading = 1'b0;
    byteValid    = 1'b0;
    byteData     = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    @(negedge clk);
  endtask

  // mode 0: always valid; 1: alternate 1/0 but held high while not ready; 2: random gaps.
  task automatic send_bytes(input int mode, output bit timeout);
    int i = 0;
    int cyc = 0;
    bit v;
    timeout = 1'b0;
    while (i < stim.size()) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        timeout = 1'b1;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1) || (byteReady !== 1'b1);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      byteValid = v;
      byteData  = v ? stim[i] : 8'($urandom);
      if (v && byteReady === 1'b1) i++;
    end
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic wait_done(output bit timeout);
    timeout = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (programLoaded === 1'b1 || loadError === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic add_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stim.push_back(byte_sum(stim.size()));
`endif
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    startLoading = 1'b0;
    byteValid    = 1'b0;
    byteData     = 8'h00;
    #23;
    n_checks++;
    if ({byteReady, imemWrite, programLoaded, loadError, imemAddr, imemData} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b wr=%b ld=%b err=%b addr=%h data=%h, want all 0",
               byteReady, imemWrite, programLoaded, loadError, imemAddr, imemData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({byteReady, imemWrite, programLoaded, loadError, imemAddr, imemData} !== 68'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got rdy=%b wr=%b ld=%b err=%b addr=%h data=%h, want all 0",
               byteReady, imemWrite, programLoaded, loadError, imemAddr, imemData);
    end
  endtask

  task automatic test_two_word();
    bit to;
    do_reset();
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    model_load(WC);
    startLoading = 1'b1;
    #1;
    n_checks++;
    if (byteReady !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b want 0", byteReady);
    end
    @(negedge clk);
    n_checks++;
    if (byteReady !== 1'b1) begin
      n_fail++;
      $display("FAIL request_latency: byteReady got %b want 1", byteReady);
    end
    send_bytes(0, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL two_word_stream_timeout: got timeout want none");
    end
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (imemWrite === 1'b1 && imemAddr === 32'(4 * (WC - 1))) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL final_write_timeout: no write at addr %h", 32'(4 * (WC - 1)));
    end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    n_checks++;
    if (programLoaded !== 1'b0) begin
      n_fail++;
      $display("FAIL loaded_during_write: got %b want 0", programLoaded);
    end
    @(negedge clk);
    n_checks++;
    if ({programLoaded, imemWrite, imemAddr, imemData} !== {1'b1, 1'b0, 32'h4, 32'h0000000C}) begin
      n_fail++;
      $display("FAIL completion_edge: got ld=%b wr=%b addr=%h data=%h want ld=1 wr=0 addr=4 data=0000000c",
               programLoaded, imemWrite, imemAddr, imemData);
    end
    startLoading = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({programLoaded, loadError, byteReady} !== 3'b100) begin
      n_fail++;
      $display("FAIL done_held: got ld=%b err=%b rdy=%b want 1 0 0", programLoaded, loadError, byteReady);
    end
`else
    stim = '{8'h39};
    send_bytes(0, to);
    wait_done(to);
    n_checks++;
    if (to || {programLoaded, loadError} !== 2'b10) begin
      n_fail++;
      $display("FAIL checksum_good: got ld=%b err=%b to=%b want ld=1 err=0", programLoaded, loadError, to);
    end
`endif
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL two_word_count: got %0d writes want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL two_word_write%0d: got addr=%h data=%h want addr=%h data=%h",
                 k, got_q[k].addr, got_q[k].data, exp_q[k].addr, exp_q[k].data);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    do_reset();
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    model_load(WC);
    add_checksum();
    startLoading = 1'b1;
    @(negedge clk);
    send_bytes(1, to);
    wait_done(to);
    n_checks++;
    if (to || programLoaded !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_done: got ld=%b to=%b want ld=1", programLoaded, to);
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL backpressure_count: got %0d writes want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL backpressure_write%0d: got addr=%h data=%h want addr=%h data=%h",
                 k, got_q[k].addr, got_q[k].data, exp_q[k].addr, exp_q[k].data);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      stim.delete();
      for (int k = 0; k < int'(4 * WC); k++) stim.push_back(8'($urandom));
      model_load(WC);
      add_checksum();
      startLoading = 1'b1;
      @(negedge clk);
      send_bytes(2, to);
      wait_done(to);
      n_checks++;
      if (to || {programLoaded, loadError} !== 2'b10) begin
        n_fail++;
        $display("FAIL random%0d_done: got ld=%b err=%b to=%b want ld=1 err=0", it, programLoaded, loadError, to);
      end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL random%0d_count: got %0d writes want %0d", it, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random%0d_write%0d: got addr=%h data=%h want addr=%h data=%h",
                   it, k, got_q[k].addr, got_q[k].data, exp_q[k].addr, exp_q[k].data);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit to;
    do_reset();
    stim = '{8'hAA, 8'hBB};
    startLoading = 1'b1;
    @(negedge clk);
    send_bytes(0, to);
    startLoading = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (byteReady !== 1'b0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_idle: got rdy=%b writes=%0d want rdy=0 writes=0", byteReady, got_q.size());
    end
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_load(1);
    startLoading = 1'b1;
    @(negedge clk);
    send_bytes(2, to);
    repeat (3) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL abort_restart_count: got %0d writes want 1", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL abort_restart_write: got addr=%h data=%h want addr=%h data=%h",
                 got_q[0].addr, got_q[0].data, exp_q[0].addr, exp_q[0].data);
      end
    end
  endtask

  task automatic test_async_reset();
    bit to;
    do_reset();
    stim = '{8'h5A, 8'hC3, 8'h7E};
    startLoading = 1'b1;
    @(negedge clk);
    send_bytes(0, to);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({byteReady, imemWrite, programLoaded, loadError, imemAddr, imemData} !== 68'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got rdy=%b wr=%b ld=%b err=%b addr=%h data=%h want all 0",
               byteReady, imemWrite, programLoaded, loadError, imemAddr, imemData);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (got_q.size() != 0 || imemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_nowrite: got writes=%0d wr=%b want 0", got_q.size(), imemWrite);
    end
    rst_n = 1'b1;
    @(negedge clk);
    stim.delete();
    for (int k = 0; k < int'(4 * WC); k++) stim.push_back(8'($urandom));
    model_load(WC);
    add_checksum();
    @(negedge clk);
    send_bytes(0, to);
    wait_done(to);
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL async_reset_fresh_load: got %0d writes, first addr=%h data=%h want addr=%h data=%h",
               got_q.size(), (got_q.size() > 0) ? got_q[0].addr : 32'hx,
               (got_q.size() > 0) ? got_q[0].data : 32'hx, exp_q[0].addr, exp_q[0].data);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum_error();
    bit to;
    do_reset();
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h3A};
    startLoading = 1'b1;
    @(negedge clk);
    send_bytes(0, to);
    wait_done(to);
    startLoading = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (to || {loadError, programLoaded, byteReady} !== 3'b100) begin
      n_fail++;
      $display("FAIL checksum_bad: got err=%b ld=%b rdy=%b to=%b want err=1 ld=0 rdy=0",
               loadError, programLoaded, byteReady, to);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_word();
    test_backpressure();
    test_random();
    test_abort();
    test_async_reset();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum_error();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Fills instruction memory from an external byte stream when the system control FSM requests a load, then reports completion. It sits between the byte source (a UART receiver or host interface) and the instruction memory write port. It is the responder to the control FSM's `startLoading` request: it drives `programLoaded`, which moves that FSM from loading to loaded. Words are assembled big-endian from four consecutive bytes and written to consecutive word-aligned byte addresses starting at 0.

## Interface
- `WORD_COUNT`, default 44: number of 32-bit instructions per program. This covers byte addresses 0..172 and must be ≥ 1.
- `CLOCK_50` in 1: system clock; all state changes on the rising edge.
- `RESET_N` in 1: reset, asynchronous and active-low.
- `startLoading` in 1: level load request from the control FSM.
- `byteData` in 8: incoming program byte.
- `byteValid` in 1: `byteData` is valid this cycle.
- `byteReady` out 1: loader accepts a byte this cycle.
- `imemAddr` out 32: instruction memory byte address, always a multiple of 4.
- `imemData` out 32: assembled instruction word.
- `imemWrite` out 1: single-cycle write strobe.
- `programLoaded` out 1: load complete; level, held.
- `loadError` out 1: checksum mismatch; level, held.

## Operation
- Byte transfer: a byte is accepted on a rising edge with `byteValid && byteReady`. No other byte is consumed.
- All outputs are registered.
- States:
  - IDLE:
    - `byteReady`=0.
    - On `startLoading`=1 → ASSEMBLE, with word index = 0, byte count = 0 and checksum = 0.
  - ASSEMBLE:
    - `byteReady`=1.
    - Each accepted byte shifts into `imemData` from the LSB side, so the first byte ends up in [31:24]. The byte count increments.
    - When the 4th byte is accepted → WRITE.
  - WRITE:
    - `byteReady`=0.
    - `imemWrite`=1 for exactly this cycle, with `imemAddr` = word index × 4.
    - If word index = `WORD_COUNT`−1 → DONE (or CHECK if the checksum feature is compiled in). Otherwise the word index increments and the state returns to ASSEMBLE.
  - CHECK (checksum builds only):
    - `byteReady`=1.
    - One accepted byte is compared against the running checksum. Match → DONE; mismatch → ERROR.
  - DONE:
    - `programLoaded`=1, `byteReady`=0.
    - Terminal; only reset leaves it.
  - ERROR:
    - `loadError`=1, `programLoaded`=0, `byteReady`=0.
    - Terminal; only reset leaves it.
- Abort: if `startLoading` falls while in ASSEMBLE, WRITE or CHECK, the next state is IDLE. Index, byte count and checksum clear, and no further writes occur. Words already written stay in memory. The next load restarts at address 0.
- Running checksum: 8-bit sum, modulo 256, of every accepted data byte. It wraps silently.
- Word index width is clog2(`WORD_COUNT`) bits, with a minimum of 1. `imemAddr` is zero-extended to 32 bits.

## Timing
- Reset values: all outputs 0, state IDLE, all internal counters 0. Reset takes effect immediately, including mid-word or mid-write, and any pending write is dropped.
- Request latency: `startLoading` sampled high at edge N → `byteReady`=1 from cycle N+1.
- Write latency: 4th byte of a word accepted at edge N → `imemWrite`=1 during cycle N+1 only. `imemAddr` and `imemData` are stable during that cycle and hold their values afterward.
- Throughput: at most one word per 5 cycles, because `byteReady` drops for the WRITE cycle. `byteValid` asserted during WRITE is not consumed.
- Completion:
  - Without checksum: `programLoaded` rises at the edge ending the final WRITE cycle.
  - With checksum: `programLoaded` rises one cycle after the checksum byte is accepted.
- `byteValid` may toggle arbitrarily. Gaps stall assembly without loss.

## Configuration
- Macro: `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last word, CHECK expects one trailing checksum byte equal to the modulo-256 sum of all data bytes.
  - Mismatch → ERROR with `loadError`=1, and `programLoaded` is never asserted.
- Undefined:
  - No CHECK or ERROR states and no checksum register.
  - `loadError` is tied to 0.
  - Final WRITE → DONE directly.

## Test plan
- Reset: hold `RESET_N`=0 → all outputs 0, `byteReady`=0. Release with `startLoading`=0 → outputs remain 0.
- Two-word load (`WORD_COUNT`=2), bytes 20 08 00 05 00 00 00 0C streamed back-to-back:
  - Expected writes: addr 0x0 data 0x20080005, then addr 0x4 data 0x0000000C, each a 1-cycle `imemWrite`.
  - Without the macro, `programLoaded`=1 at the edge ending the second write.
- Backpressure: `byteValid` alternates 1/0 and is also held high through the WRITE cycles → identical writes to the two-word load, and no byte is consumed while `byteReady`=0.
- Abort: drop `startLoading` after 2 bytes → IDLE with no write. Re-assert and stream 4 bytes → write at addr 0x0 containing only the new bytes.
- Async reset asserted mid-word, after 3 bytes → outputs 0 immediately with no write strobe. After release, a fresh load starts at addr 0.
- With `PROGRAM_LOADER_CHECKSUM_EN`, using the two-word stream above:
  - Trailing byte 0x39 → `programLoaded`=1, `loadError`=0.
  - Trailing byte 0x3A → `loadError`=1, `programLoaded`=0, and both are held until reset.
